// File: rtl/avr_pkg.sv
// Shared ATmega32A core definitions: decoded instruction IDs, interrupt-entry
// stage encoding and the per-instruction cycle count table.
package avr_pkg;

    localparam logic [7:0] ID_NOP       = 8'h00;
    localparam logic [7:0] ID_BRANCH_LO = 8'h04;
    localparam logic [7:0] ID_BRANCH_HI = 8'h08;
    localparam logic [7:0] ID_CLI       = 8'h0A;
    localparam logic [7:0] ID_LD        = 8'h19;
    localparam logic [7:0] ID_LPM       = 8'h22;
    localparam logic [7:0] ID_POP       = 8'h2A;
    localparam logic [7:0] ID_PUSH      = 8'h2B;
    localparam logic [7:0] ID_RCALL     = 8'h2C;
    localparam logic [7:0] ID_RET       = 8'h2D;
    localparam logic [7:0] ID_RETI      = 8'h2E;
    localparam logic [7:0] ID_RJMP      = 8'h2F;
    localparam logic [7:0] ID_SEI       = 8'h32;
    localparam logic [7:0] ID_ST        = 8'h38;

    // Encoding is shared with control_mux, hence the non-sequential values.
    typedef enum logic [1:0] {
        IRQ_IDLE   = 2'd0,
        IRQ_PUSH_H = 2'd1,
        IRQ_PUSH_L = 2'd2,
        IRQ_VECTOR = 2'd3
    } irq_stage_t;

    function automatic logic [2:0] cycles_of(input logic [7:0] id, input logic taken);
        logic [2:0] n;
        n = 3'd1;
        if (id == ID_RET || id == ID_RETI)
            n = 3'd4;
        else if (id == ID_RCALL || id == ID_LPM)
            n = 3'd3;
        else if (id == ID_PUSH || id == ID_POP || id == ID_LD || id == ID_ST || id == ID_RJMP)
            n = 3'd2;
        else if (id >= ID_BRANCH_LO && id <= ID_BRANCH_HI)
            n = taken ? 3'd2 : 3'd1;
        return n;
    endfunction

endpackage

// File: rtl/cycle_sequencer.sv
// Multi-cycle instruction and interrupt-entry sequencer: counts instruction
// cycles, stalls fetch, and runs the three-stage interrupt entry at boundaries.
module cycle_sequencer
    import avr_pkg::*;
#(
    parameter int unsigned RETI_GUARD = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] instruction_id,
    input  logic       branch_taken,
    input  logic       irq_req,
    input  logic       sreg_i,
    output logic [1:0] clock_counter,
    output logic [1:0] interrupt_stage,
    output logic       pc_hold,
    output logic       instr_retire,
    output logic       irq_ack
);

    logic [1:0] counter_q, counter_d;
    irq_stage_t stage_q, stage_d;
    logic       retire_q, retire_d;
    logic       ack_q, ack_d;
    logic       guard_q, guard_d;
    logic [7:0] cur_id_q, cur_id_d;

    logic       boundary;
    logic       irq_take;
    logic [2:0] issue_cycles;
    logic [7:0] retire_id;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        counter_d    = counter_q;
        stage_d      = stage_q;
        cur_id_d     = cur_id_q;
        guard_d      = guard_q;
        retire_d     = 1'b0;
        retire_id    = cur_id_q;
        boundary     = (counter_q == 2'd0) && (stage_q == IRQ_IDLE);
        irq_take     = boundary && irq_req && sreg_i && !((RETI_GUARD != 0) && guard_q);
        issue_cycles = cycles_of(instruction_id, branch_taken);

        if (boundary) begin
            if (irq_take) begin
                stage_d = IRQ_PUSH_L;
            end else begin
                counter_d = 2'(issue_cycles - 3'd1);
                cur_id_d  = instruction_id;
                retire_id = instruction_id;
                retire_d  = (issue_cycles == 3'd1);
            end
        end else if (counter_q != 2'd0) begin
            counter_d = counter_q - 2'd1;
            retire_d  = (counter_q == 2'd1);
        end else begin
            case (stage_q)
                IRQ_PUSH_L: stage_d = IRQ_PUSH_H;
                IRQ_PUSH_H: stage_d = IRQ_VECTOR;
                IRQ_VECTOR: stage_d = IRQ_IDLE;
                default:    stage_d = IRQ_IDLE;
            endcase
        end

        ack_d = (stage_d == IRQ_VECTOR);

        // The guard follows the most recently retired instruction, so a single
        // retire after RETI/SEI both sets and clears it; interrupt entry leaves it alone.
        if ((RETI_GUARD != 0) && retire_d)
            guard_d = (retire_id == ID_RETI) || (retire_id == ID_SEI);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter_q <= 2'd0;
            stage_q   <= IRQ_IDLE;
            retire_q  <= 1'b0;
            ack_q     <= 1'b0;
            guard_q   <= 1'b0;
            cur_id_q  <= ID_NOP;
        end else begin
            counter_q <= counter_d;
            stage_q   <= stage_d;
            retire_q  <= retire_d;
            ack_q     <= ack_d;
            guard_q   <= guard_d;
            cur_id_q  <= cur_id_d;
        end
    end

    assign clock_counter   = counter_q;
    assign interrupt_stage = stage_q;
    assign instr_retire    = retire_q;
    assign irq_ack         = ack_q;
    assign pc_hold         = (counter_q != 2'd0) || (stage_q != IRQ_IDLE) || irq_take;

endmodule

// File: doc/cycle_sequencer.md
# cycle_sequencer

Multi-cycle instruction and interrupt-entry sequencer for the ATmega32A core. It sits between the instruction decoder and `control_mux`. It is the producer of the `clock_counter` and `interrupt_stage` signals that `control_mux` consumes. It decides how many cycles each decoded `instruction_id` occupies, stalls fetch while an instruction or interrupt entry is in progress, and runs the interrupt-entry sequence at instruction boundaries.

## Interface
- `RETI_GUARD`, default 1: when 1, one instruction must retire after RETI/SEI before an interrupt is accepted.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `instruction_id`  in  8  decoded instruction ID; valid whenever `pc_hold`=0.
- `branch_taken`  in  1  branch condition result for IDs 0x04–0x08; sampled with `instruction_id`.
- `irq_req`  in  1  level; at least one enabled interrupt is pending.
- `sreg_i`  in  1  global interrupt enable (SREG.I).
- `clock_counter`  out  2  cycles remaining in the current instruction; counts down to 0.
- `interrupt_stage`  out  2  0 = idle, 2 = push PC low, 1 = push PC high, 3 = load vector.
- `pc_hold`  out  1  combinational; stalls PC increment and fetch.
- `instr_retire`  out  1  registered one-cycle pulse; the current instruction finished.
- `irq_ack`  out  1  registered one-cycle pulse during stage 3; clears the pending flag and SREG.I.

## Operation
- Cycle counts (function `cycles_of(id, taken)`):
  - RCALL 0x2C = 3.
  - RET 0x2D and RETI 0x2E = 4.
  - LPM 0x22 = 3.
  - PUSH 0x2B, POP 0x2A, LD 0x19, ST 0x38, RJMP 0x2F = 2.
  - Branches 0x04–0x08 = 2 if `branch_taken`, else 1.
  - All other IDs = 1.
- A boundary cycle is one where `clock_counter`=0 and `interrupt_stage`=0.
- `irq_take` = boundary & `irq_req` & `sreg_i` & ~`guard`.
- At a boundary:
  - If `irq_take`: `interrupt_stage` ← 2. The presented instruction is discarded. The PC is not advanced, so the instruction is refetched after the handler returns.
  - Else: issue the instruction. `clock_counter` ← `cycles_of` − 1, and `cur_id` ← `instruction_id`.
- When `clock_counter` ≠ 0: it decrements by 1 each cycle. It never wraps below 0.
- Interrupt state machine: IDLE(0) → PUSH_L(2) → PUSH_H(1) → VECTOR(3) → IDLE(0), one cycle per state. `irq_ack` ← 1 for the cycle `interrupt_stage`=3.
- `clock_counter` stays 0 throughout interrupt entry.
- `pc_hold` = (`clock_counter` ≠ 0) | (`interrupt_stage` ≠ 0) | `irq_take`.
  - For a 1-cycle instruction, `pc_hold`=0 in its issue cycle.
  - For an N-cycle instruction, `pc_hold` is high for N−1 cycles.
- `instr_retire` is pulsed in the cycle after either:
  - a 1-cycle instruction issues, or
  - `clock_counter` goes from 1 to 0.
- Guard flag (only when `RETI_GUARD`=1):
  - Set on the retire of `cur_id` 0x2E or 0x32.
  - Cleared on the next retire of any other instruction.
  - Interrupt entry does not clear it.
- Simultaneous events:
  - `irq_req` arriving mid-instruction waits until the boundary.
  - `irq_req` dropping during stages 2/1/3 does not abort the sequence.
  - `sreg_i` is ignored outside boundary cycles.

## Timing
- Reset values (asynchronous, immediate on `reset_n`=0):
  - `clock_counter`=0, `interrupt_stage`=0, `instr_retire`=0, `irq_ack`=0.
  - `guard`=0, `cur_id`=0x00.
  - `pc_hold` therefore becomes 0 unless `irq_take` is asserted.
- Reset asserted mid-instruction or mid-interrupt abandons the sequence with no partial completion.
- First boundary is the first rising edge after reset deassertion.
- Issue-to-output latency: `clock_counter` and `interrupt_stage` are valid one cycle after the issuing edge. `control_mux` registers its outputs on the following edge.
- Interrupt entry latency from `irq_take` cycle to vector load is 3 cycles (stages 2, 1, 3). Fetch resumes in the cycle after stage 3.
- Worst-case interrupt latency:
  - RET/RETI in progress (3 extra cycles), plus
  - one guarded instruction of up to 4 cycles, plus 3 entry cycles.

## Structure
- Shared package `avr_pkg`:
  - instruction ID constants (`ID_RCALL`=8'h2C, `ID_RET`, `ID_RETI`, `ID_SEI`=8'h32, `ID_CLI`=8'h0A, …);
  - `irq_stage_t` encoding (IDLE=0, PUSH_L=2, PUSH_H=1, VECTOR=3);
  - the `cycles_of` function.
  - The same constants are also to be consumed by `control_mux` and the decoder.
- Single module; no sub-module is needed. The counter and interrupt state machine are each small.

## Test plan
- Reset mid-RCALL: issue 0x2C, then assert `reset_n`=0 when `clock_counter`=1 → `clock_counter`=0, `interrupt_stage`=0, `pc_hold`=0 immediately, with no `instr_retire`.
- RCALL 0x2C at a boundary → `clock_counter` reads 2, 1, 0 on successive cycles; `pc_hold` high 2 cycles; one `instr_retire` pulse.
- Branch 0x05 with `branch_taken`=1 → `clock_counter` 1 then 0. With `branch_taken`=0 → `clock_counter` stays 0, `pc_hold` stays 0, `instr_retire` the next cycle.
- `irq_req`=1, `sreg_i`=1 at a boundary presenting ADD → `interrupt_stage` 2, 1, 3, 0; `irq_ack` high only in the stage-3 cycle; ADD not issued; `pc_hold` high 4 cycles.
- `irq_req` rises during RET (`clock_counter`=3) → no stage change until `clock_counter`=0; entry starts at the next boundary.
- RETI retires with `irq_req` held high → the next instruction (e.g. 0x2B PUSH, 2 cycles) fully retires before `interrupt_stage` becomes 2. With `RETI_GUARD`=0, entry starts at the immediate boundary.
